alu_mult_sequencer: RTL and testbench
=====================================

Name: alu_mult_sequencer

Overview:
Multi-cycle unsigned shift-and-add multiply controller for the execute stage. It has no adder of its own: it borrows the shared execute-stage ALU through a request/grant handshake and drives the ALU's 7-bit control word and operands. It returns the low WIDTH bits of the product, which are correct for both signed and unsigned operands.

Parameters:
WIDTH, 16, operand/result width; also the maximum iteration count.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  begin a multiply; sampled only in IDLE.
op_a  input  WIDTH  multiplicand; captured when start is accepted.
op_b  input  WIDTH  multiplier; captured when start is accepted.
busy  output  1  high in REQ, RUN and DONE.
done  output  1  one-cycle pulse in DONE.
result  output  WIDTH  low WIDTH bits of op_a*op_b; holds until the next accepted start.
alu_req  output  1  request for the shared ALU.
alu_gnt  input  1  grant from the execute-stage ALU mux.
alu_a  output  WIDTH  ALU input A, equal to the accumulator.
alu_b  output  WIDTH  ALU input B, equal to the shifted multiplicand.
alu_ctrl  output  7  ALU control word; bits 2:0 opcode, 3 invA, 4 invB, 5 sign, 6 Cin.
alu_out  input  WIDTH  combinational ALU result.

Behaviour:
- Reset (async, rst_n=0): state IDLE. acc, mcand, mplier, count, result are 0. busy, done, alu_req are 0. alu_ctrl is 7'h00.
- Reset mid-operation aborts immediately. No partial result is kept.
- Internal registers:
  - acc: accumulator, WIDTH bits.
  - mcand: shifted multiplicand, WIDTH bits; bits shifted out the top are discarded.
  - mplier: remaining multiplier, WIDTH bits.
  - count: iterations left, clog2(WIDTH)+1 bits.
- IDLE:
  - start=1 → acc=0, mcand=op_a, mplier=op_b, count=WIDTH, next state REQ.
  - start=0 → stay in IDLE.
  - Exception (early-exit feature only): start=1 with op_b==0 → result=0, next state DONE, and the ALU is never requested.
- REQ: alu_req=1. alu_gnt=1 at the clock edge → RUN; otherwise stay in REQ.
- RUN: alu_req=1. alu_ctrl=7'h04 (ADD, no inversion, unsigned, Cin=0). alu_a=acc, alu_b=mcand.
  - An iteration happens only on an edge where alu_gnt=1:
    - if mplier[0]=1, acc←alu_out;
    - mcand←mcand<<1;
    - mplier←mplier>>1;
    - count←count-1.
  - alu_gnt=0 → stall: no register changes, alu_req stays 1.
  - Termination: on the edge where count reaches 0 (or mplier>>1 is 0 under early exit), result←final acc value (including that iteration's add), next state DONE.
- DONE: done=1 and busy=1 for exactly one cycle. alu_req=0. alu_ctrl=7'h00. Next state IDLE.
- Outside RUN: alu_a=0, alu_b=0, alu_ctrl=7'h00.
- start while busy=1 is ignored and has no side effects.
- Addition wraps modulo 2^WIDTH. Carry-out is not used.
- Latency with alu_gnt held at 1, start accepted at edge E0:
  - REQ during E0→E1;
  - iterations on E2..E(1+N);
  - done high in the cycle after E(1+N).
  - N=WIDTH, or N=bit position of op_b's MSB set + 1 under early exit.
  - Each stalled cycle adds 1 to the latency.

Optional Feature:
Macro ALU_MULT_EARLY_EXIT_EN.
- Defined:
  - RUN terminates once the remaining multiplier is 0.
  - op_b==0 goes IDLE→DONE directly with result 0 and alu_req never asserted.
- Undefined:
  - always exactly WIDTH iterations;
  - op_b==0 follows the normal REQ/RUN path and yields result 0.

Test Plan:
1. alu_gnt tied 1, op_a=3, op_b=5, start at E0.
   - Early exit defined: result=15, done high after E4, exactly 3 iterations.
   - Early exit undefined: result=15, done high after E17.
2. op_a=16'hFFFF, op_b=16'hFFFF, gnt=1 → result=16'h0001. Also op_a=16'hFFFE (-2), op_b=16'h0003 → result=16'hFFFA (-6).
3. op_a=7, op_b=9, alu_gnt dropped for 3 cycles after the first iteration → alu_req stays 1, registers frozen during the stall, result=63, done 3 cycles later than the unstalled run.
4. op_b=0, op_a=16'h1234:
   - Early exit defined: done high one cycle after start, result=0, alu_req never asserted.
   - Early exit undefined: result=0 after the full WIDTH iterations.
5. rst_n pulsed low mid-RUN → busy, done, alu_req, result, alu_ctrl go to 0 asynchronously. A following start with 4*4 gives result=16.
6. Second start asserted during RUN with different operands → ignored. The first result is delivered, and done pulses exactly once.

Source files
------------

// File: rtl/alu_mult_sequencer.sv
// Shift-and-add multiply sequencer that borrows the shared execute-stage ALU via req/gnt.
// Optional macro ALU_MULT_EARLY_EXIT_EN: stop once the remaining multiplier is zero.
module alu_mult_sequencer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             alu_req,
   input  logic             alu_gnt,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [6:0]       alu_ctrl,
   input  logic [WIDTH-1:0] alu_out
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH);
   localparam logic [6:0]    CTRL_ADD   = 7'h04;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state_r, state_s;
   logic [WIDTH-1:0] acc_r, acc_s;
   logic [WIDTH-1:0] mcand_r, mcand_s;
   logic [WIDTH-1:0] mplier_r, mplier_s;
   logic [WIDTH-1:0] result_r, result_s;
   logic [CW-1:0]    count_r, count_s;
   logic             busy_r, done_r, req_r;
   logic [6:0]       ctrl_r;
   logic             last_s;

   // Final iteration: counter exhausted, or (early exit) no multiplier bits left after this one.
`ifdef ALU_MULT_EARLY_EXIT_EN
   assign last_s = (count_r == CW'(1)) || (mplier_r[WIDTH-1:1] == {(WIDTH-1){1'b0}});
`else
   assign last_s = (count_r == CW'(1));
`endif

   // Next-state and datapath update logic.
   always_comb begin
      state_s  = state_r;
      acc_s    = acc_r;
      mcand_s  = mcand_r;
      mplier_s = mplier_r;
      result_s = result_r;
      count_s  = count_r;
      case (state_r)
         IDLE: begin
            if (start) begin
`ifdef ALU_MULT_EARLY_EXIT_EN
               if (op_b == {WIDTH{1'b0}}) begin
                  result_s = {WIDTH{1'b0}};
                  state_s  = DONE;
               end else begin
                  acc_s    = {WIDTH{1'b0}};
                  mcand_s  = op_a;
                  mplier_s = op_b;
                  count_s  = COUNT_INIT;
                  state_s  = REQ;
               end
`else
               acc_s    = {WIDTH{1'b0}};
               mcand_s  = op_a;
               mplier_s = op_b;
               count_s  = COUNT_INIT;
               state_s  = REQ;
`endif
            end else begin
               state_s = IDLE;
            end
         end
         REQ: begin
            if (alu_gnt) begin
               state_s = RUN;
            end else begin
               state_s = REQ;
            end
         end
         RUN: begin
            if (alu_gnt) begin
               if (mplier_r[0]) begin
                  acc_s = alu_out;
               end else begin
                  acc_s = acc_r;
               end
               mcand_s  = mcand_r << 1;
               mplier_s = mplier_r >> 1;
               count_s  = count_r - CW'(1);
               if (last_s) begin
                  result_s = acc_s;
                  state_s  = DONE;
               end else begin
                  state_s = RUN;
               end
            end else begin
               state_s = RUN;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, datapath and registered control outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         acc_r    <= {WIDTH{1'b0}};
         mcand_r  <= {WIDTH{1'b0}};
         mplier_r <= {WIDTH{1'b0}};
         result_r <= {WIDTH{1'b0}};
         count_r  <= {CW{1'b0}};
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         req_r    <= 1'b0;
         ctrl_r   <= 7'h00;
      end else begin
         state_r  <= state_s;
         acc_r    <= acc_s;
         mcand_r  <= mcand_s;
         mplier_r <= mplier_s;
         result_r <= result_s;
         count_r  <= count_s;
         busy_r   <= (state_s != IDLE);
         done_r   <= (state_s == DONE);
         req_r    <= (state_s == REQ) || (state_s == RUN);
         ctrl_r   <= (state_s == RUN) ? CTRL_ADD : 7'h00;
      end
   end

   assign busy     = busy_r;
   assign done     = done_r;
   assign alu_req  = req_r;
   assign alu_ctrl = ctrl_r;
   assign result   = result_r;
   assign alu_a    = (state_r == RUN) ? acc_r   : {WIDTH{1'b0}};
   assign alu_b    = (state_r == RUN) ? mcand_r : {WIDTH{1'b0}};

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Scoreboard bench for alu_mult_sequencer; expected products and done timing come from plain arithmetic.
module tb_alu_mult_sequencer;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] op_a = '0;
   logic [W-1:0] op_b = '0;
   logic         alu_gnt = 1'b1;
   logic         busy, done, alu_req;
   logic [W-1:0] result, alu_a, alu_b, alu_out;
   logic [6:0]   alu_ctrl;

   alu_mult_sequencer #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
      .busy(busy), .done(done), .result(result), .alu_req(alu_req),
      .alu_gnt(alu_gnt), .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
      .alu_out(alu_out)
   );

   always #5 clk = ~clk;

   // Shared ALU stand-in: only the ADD control word yields a sum.
   assign alu_out = (alu_ctrl == 7'h04) ? alu_a + alu_b : alu_a ^ alu_b;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] res;
      int           done_cyc;
   } exp_t;
   exp_t sb[$];

   int checks = 0;
   int errors = 0;
   int dones_seen = 0;
   int dones_exp = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Iterations the multiply should take for a given multiplier.
   function automatic int n_iter(input logic [W-1:0] b);
`ifdef ALU_MULT_EARLY_EXIT_EN
      for (int i = W - 1; i >= 0; i--) begin
         if (b[i]) return i + 1;
      end
      return 0;
`else
      return W;
`endif
   endfunction

   // Cycle (posedge count) at whose following negedge done must be high; start taken at edge e0.
   function automatic int done_at(input int e0, input logic [W-1:0] b);
`ifdef ALU_MULT_EARLY_EXIT_EN
      if (b == '0) return e0;
`endif
      return e0 + 1 + n_iter(b);
   endfunction

   // Called at a negedge with the DUT idle; stalls < 0 means latency is not checked.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input int stalls);
      exp_t e;
      int   e0;
      op_a  = a;
      op_b  = b;
      start = 1'b1;
      e0    = cyc + 1;
      e.res = W'(32'(a) * 32'(b));
      e.done_cyc = (stalls < 0) ? -1 : done_at(e0, b) + stalls;
      sb.push_back(e);
      dones_exp++;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input bit rnd_gnt);
      int k = 0;
      while (busy && k < 400) begin
         if (rnd_gnt) alu_gnt = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         k++;
      end
      alu_gnt = 1'b1;
      check("idle_timeout", {31'd0, busy}, 32'd0);
      @(negedge clk);
   endtask

   // Monitor: every done pulse consumes one scoreboard entry.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && done) begin
            dones_seen++;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
            end else begin
               e = sb.pop_front();
               check("result", 32'(result), 32'(e.res));
               if (e.done_cyc >= 0) check("done_cycle", cyc, e.done_cyc);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

   initial begin
      logic [W-1:0] ra, rb;
      #1;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_req", {31'd0, alu_req}, 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_ctrl", 32'(alu_ctrl), 32'd0);
      check("rst_alu_a", 32'(alu_a), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic product and latency.
      issue(16'd3, 16'd5, 0);
      wait_idle(1'b0);

      // Wraparound / signed-equivalent products.
      issue(16'hFFFF, 16'hFFFF, 0);
      wait_idle(1'b0);
      issue(16'hFFFE, 16'h0003, 0);
      wait_idle(1'b0);

      // Grant withdrawn for 3 cycles after the first iteration.
      issue(16'd7, 16'd9, 3);
      @(negedge clk);
      @(negedge clk);
      alu_gnt = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_req", {31'd0, alu_req}, 32'd1);
         check("stall_acc", 32'(alu_a), 32'd7);
         check("stall_mcand", 32'(alu_b), 32'd14);
         check("stall_ctrl", 32'(alu_ctrl), 32'h04);
      end
      alu_gnt = 1'b1;
      wait_idle(1'b0);

      // Asynchronous reset in the middle of RUN.
      issue(16'h1234, 16'h0055, -1);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_done", {31'd0, done}, 32'd0);
      check("arst_req", {31'd0, alu_req}, 32'd0);
      check("arst_result", 32'(result), 32'd0);
      check("arst_ctrl", 32'(alu_ctrl), 32'd0);
      sb.delete();
      dones_exp--;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      issue(16'd4, 16'd4, 0);
      wait_idle(1'b0);

      // Zero multiplier.
      issue(16'h1234, 16'h0000, 0);
`ifdef ALU_MULT_EARLY_EXIT_EN
      check("zero_no_req", {31'd0, alu_req}, 32'd0);
`endif
      wait_idle(1'b0);

      // Start while busy must be ignored.
      issue(16'h0101, 16'h0203, 0);
      @(negedge clk);
      op_a  = 16'h0011;
      op_b  = 16'h0022;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle(1'b0);

      // Randomized operands with random grant stalls.
      for (int n = 0; n < 40; n++) begin
         ra = W'($urandom);
         case (n % 4)
            0: rb = W'($urandom_range(0, 15));
            1: rb = '0;
            default: rb = W'($urandom);
         endcase
         issue(ra, rb, -1);
         wait_idle(1'b1);
      end

      check("done_count", dones_seen, dones_exp);
      check("sb_empty", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
